// File: rtl/calc_accum_if.sv
// Keypad-to-accumulator bus: key handshake in, entry/result/status out.
interface calc_accum_if #(
  parameter int NDIG = 4
);
  localparam int W = 4 * NDIG;

  logic         valid_input;
  logic         ready;
  logic [4:0]   input_value;
  logic [W-1:0] inreg;
  logic [W-1:0] result;
  logic         ovf;
  logic         busy;

  modport master (
    output valid_input, input_value,
    input  ready, inreg, result, ovf, busy
  );

  modport slave (
    input  valid_input, input_value,
    output ready, inreg, result, ovf, busy
  );
endinterface

// File: rtl/calc_accum_unit.sv
// Hex-keypad accumulator calculator with wrap/saturate arithmetic and sticky overflow.
// Define CALC_MUL_EN to enable the '*' operator (radix-2 shift-add over W cycles).
module calc_accum_unit #(
  parameter int NDIG = 4,
  parameter int SAT  = 0
) (
  input logic         clk,
  input logic         nrst,
  calc_accum_if.slave bus
);
  localparam int W = 4 * NDIG;
  localparam logic [W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

  logic [W-1:0] inreg_reg, inreg_next;
  logic [W-1:0] result_reg, result_next;
  logic         ovf_reg, ovf_next;
  op_t          pend_reg, pend_next;

  logic [W-1:0] shifted;
  logic [W:0]   sum, diff;
  logic         fire, is_digit, is_op, busy;
  op_t          new_op;

`ifdef CALC_MUL_EN
  localparam int CW = $clog2(W);
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [2*W-1:0] mcand_reg, mcand_next;
  logic [2*W-1:0] acc_reg, acc_next, acc_sum;
  logic [W-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  assign busy = (state_reg == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  assign bus.busy   = busy;
  assign bus.ready  = ~busy;
  assign bus.inreg  = inreg_reg;
  assign bus.result = result_reg;
  assign bus.ovf    = ovf_reg;
  assign fire       = bus.valid_input & ~busy;

  // New digit enters at the bottom; the top nibble falls off silently.
  genvar gi;
  generate
    for (gi = 1; gi < NDIG; gi++) begin : g_shift
      assign shifted[4*gi +: 4] = inreg_reg[4*(gi-1) +: 4];
    end
  endgenerate
  assign shifted[3:0] = bus.input_value[3:0];

  assign sum  = {1'b0, result_reg} + {1'b0, inreg_reg};
  assign diff = {1'b0, result_reg} - {1'b0, inreg_reg};

  always_comb begin
    is_digit = ~bus.input_value[4];
    is_op    = 1'b0;
    new_op   = OP_ADD;
    case (bus.input_value)
      5'h10: is_op = 1'b1;
      5'h11: begin is_op = 1'b1; new_op = OP_SUB; end
      5'h12: is_op = 1'b1;
`ifdef CALC_MUL_EN
      5'h14: begin is_op = 1'b1; new_op = OP_MUL; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    inreg_next  = inreg_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    pend_next   = pend_reg;
`ifdef CALC_MUL_EN
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    acc_sum     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif
    if (fire) begin
      if (is_digit) begin
        inreg_next = shifted;
      end else if (bus.input_value == 5'h15) begin
        inreg_next = '0;
      end else if (bus.input_value == 5'h13) begin
        inreg_next  = '0;
        result_next = '0;
        ovf_next    = 1'b0;
        pend_next   = OP_ADD;
      end else if (is_op) begin
        inreg_next = '0;
        pend_next  = new_op;
        case (pend_reg)
          OP_SUB: begin
            result_next = diff[W-1:0];
            if (diff[W]) begin
              ovf_next = 1'b1;
              if (SAT != 0) result_next = '0;
            end
          end
`ifdef CALC_MUL_EN
          OP_MUL: begin
            // Result register keeps its old value until the product lands.
            state_next  = ST_MUL;
            mcand_next  = {{W{1'b0}}, result_reg};
            mplier_next = inreg_reg;
            acc_next    = '0;
            cnt_next    = '0;
          end
`endif
          default: begin
            result_next = sum[W-1:0];
            if (sum[W]) begin
              ovf_next = 1'b1;
              if (SAT != 0) result_next = ALL_ONES;
            end
          end
        endcase
      end
    end
`ifdef CALC_MUL_EN
    if (state_reg == ST_MUL) begin
      acc_next    = acc_sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg + CW'(1);
      if (cnt_reg == CW'(W - 1)) begin
        state_next  = ST_IDLE;
        result_next = acc_sum[W-1:0];
        if (|acc_sum[2*W-1:W]) begin
          ovf_next = 1'b1;
          if (SAT != 0) result_next = ALL_ONES;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inreg_reg  <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      pend_reg   <= OP_ADD;
`ifdef CALC_MUL_EN
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
`endif
    end else begin
      inreg_reg  <= inreg_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      pend_reg   <= pend_next;
`ifdef CALC_MUL_EN
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
`endif
    end
  end
endmodule

// File: tb/tb_calc_accum_unit.sv
// Bench for calc_accum_unit: a wrapping and a saturating instance driven with identical keys.
module tb_calc_accum_unit;
  localparam int     NDIG = 4;
  localparam int     W    = 4 * NDIG;
  localparam longint MOD  = 64'd1 << W;
  localparam longint MAXV = MOD - 1;
`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  calc_accum_if #(.NDIG(NDIG)) b0 ();
  calc_accum_if #(.NDIG(NDIG)) b1 ();

  calc_accum_unit #(.NDIG(NDIG), .SAT(0)) dut0 (.clk(clk), .nrst(nrst), .bus(b0));
  calc_accum_unit #(.NDIG(NDIG), .SAT(1)) dut1 (.clk(clk), .nrst(nrst), .bus(b1));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int     key;
    longint inreg;
    longint r0;
    bit     o0;
    longint r1;
    bit     o1;
  } vec_t;

  typedef struct {
    longint inreg;
    longint result;
    bit     ovf;
    int     pend;   // 0 add, 1 sub, 2 mul
  } mstate_t;

  vec_t    vecs[$];
  mstate_t m0, m1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t v(input int k, input longint ir, input longint r0, input bit o0,
                             input longint r1, input bit o1);
    vec_t x;
    x.key = k; x.inreg = ir; x.r0 = r0; x.o0 = o0; x.r1 = r1; x.o1 = o1;
    return x;
  endfunction

  // Calculator semantics in plain integer arithmetic.
  function automatic mstate_t model_key(input mstate_t s, input bit sat, input int k);
    mstate_t n;
    longint  a, b, r;
    int      op;
    n  = s;
    op = -1;
    if (k < 16) begin
      n.inreg = (s.inreg * 16 + k) % MOD;
    end else if (k == 'h13) begin
      n.inreg = 0; n.result = 0; n.ovf = 1'b0; n.pend = 0;
    end else if (k == 'h15) begin
      n.inreg = 0;
    end else begin
      case (k)
        'h10, 'h12: op = 0;
        'h11:       op = 1;
        'h14:       op = MUL_EN ? 2 : -1;
        default:    op = -1;
      endcase
      if (op >= 0) begin
        a = s.result;
        b = s.inreg;
        case (s.pend)
          1:       r = a - b;
          2:       r = a * b;
          default: r = a + b;
        endcase
        if (r < 0) begin
          n.ovf = 1'b1; r = sat ? 0 : r + MOD;
        end else if (r > MAXV) begin
          n.ovf = 1'b1; r = sat ? MAXV : r % MOD;
        end
        n.result = r; n.inreg = 0; n.pend = op;
      end
    end
    return n;
  endfunction

  task automatic drive(input bit vld, input int k);
    b0.valid_input = vld; b1.valid_input = vld;
    b0.input_value = 5'(k); b1.input_value = 5'(k);
  endtask

  // Offer one key, then wait until the unit is idle again; leaves time at posedge+1.
  task automatic send_key(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!b0.ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("ready_before_key", 0, 1);
    drive(1'b1, k);
    @(posedge clk); #1;
    drive(1'b0, 0);
    guard = 0;
    while (!b0.ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (guard >= 100) check("ready_after_key", 0, 1);
    $display("key %02h inreg %04h result0 %04h ovf0 %0d result1 %04h ovf1 %0d",
             k, b0.inreg, b0.result, b0.ovf, b1.result, b1.ovf);
  endtask

  task automatic check_model(input string tag);
    check({tag, " inreg0"},  b0.inreg,  m0.inreg);
    check({tag, " result0"}, b0.result, m0.result);
    check({tag, " ovf0"},    b0.ovf,    m0.ovf);
    check({tag, " inreg1"},  b1.inreg,  m1.inreg);
    check({tag, " result1"}, b1.result, m1.result);
    check({tag, " ovf1"},    b1.ovf,    m1.ovf);
  endtask

  initial begin
    int cnt, k;
    drive(1'b0, 0);

    // Table: sums, differences, wrap/saturate, digit shifting, CE, ignored codes.
    vecs.push_back(v('h01, 'h1, 0, 0, 0, 0));
    vecs.push_back(v('h00, 'h10, 0, 0, 0, 0));
    vecs.push_back(v('h00, 'h100, 0, 0, 0, 0));
    vecs.push_back(v('h10, 0, 'h100, 0, 'h100, 0));
    vecs.push_back(v('h08, 'h8, 'h100, 0, 'h100, 0));
    vecs.push_back(v('h00, 'h80, 'h100, 0, 'h100, 0));
    vecs.push_back(v('h11, 0, 'h180, 0, 'h180, 0));
    vecs.push_back(v('h06, 'h6, 'h180, 0, 'h180, 0));
    vecs.push_back(v('h00, 'h60, 'h180, 0, 'h180, 0));
    vecs.push_back(v('h12, 0, 'h120, 0, 'h120, 0));
    vecs.push_back(v('h13, 0, 0, 0, 0, 0));
    vecs.push_back(v('h0F, 'hF, 0, 0, 0, 0));
    vecs.push_back(v('h0F, 'hFF, 0, 0, 0, 0));
    vecs.push_back(v('h0F, 'hFFF, 0, 0, 0, 0));
    vecs.push_back(v('h0F, 'hFFFF, 0, 0, 0, 0));
    vecs.push_back(v('h10, 0, 'hFFFF, 0, 'hFFFF, 0));
    vecs.push_back(v('h01, 'h1, 'hFFFF, 0, 'hFFFF, 0));
    vecs.push_back(v('h12, 0, 'h0000, 1, 'hFFFF, 1));
    vecs.push_back(v('h13, 0, 0, 0, 0, 0));
    vecs.push_back(v('h05, 'h5, 0, 0, 0, 0));
    vecs.push_back(v('h11, 0, 'h5, 0, 'h5, 0));
    vecs.push_back(v('h07, 'h7, 'h5, 0, 'h5, 0));
    vecs.push_back(v('h12, 0, 'hFFFE, 1, 'h0000, 1));
    vecs.push_back(v('h01, 'h1, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h02, 'h12, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h03, 'h123, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h04, 'h1234, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h05, 'h2345, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h15, 0, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h17, 0, 'hFFFE, 1, 0, 1));
    vecs.push_back(v('h13, 0, 0, 0, 0, 0));

    // Reset state, entered asynchronously between clock edges.
    #2 nrst = 1'b0;
    #1;
    check("rst inreg",  b0.inreg,  0);
    check("rst result", b0.result, 0);
    check("rst ovf",    b0.ovf,    0);
    check("rst busy",   b0.busy,   0);
    check("rst ready",  b0.ready,  1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) begin
      send_key(vecs[i].key);
      check($sformatf("vec%0d inreg0", i),  b0.inreg,  vecs[i].inreg);
      check($sformatf("vec%0d result0", i), b0.result, vecs[i].r0);
      check($sformatf("vec%0d ovf0", i),    b0.ovf,    vecs[i].o0);
      check($sformatf("vec%0d inreg1", i),  b1.inreg,  vecs[i].inreg);
      check($sformatf("vec%0d result1", i), b1.result, vecs[i].r1);
      check($sformatf("vec%0d ovf1", i),    b1.ovf,    vecs[i].o1);
    end

    // 0x14: operator with the multiplier, otherwise ignored.
    send_key('h07); send_key('h10); send_key('h03); send_key('h14);
    check("key14 inreg",  b0.inreg,  MUL_EN ? 0 : 3);
    check("key14 result", b0.result, MUL_EN ? 'hA : 7);
    check("key14 busy",   b0.busy,   0);
    send_key('h13);

`ifdef CALC_MUL_EN
    // 0x12 * 0x34 with a CL held throughout the busy window.
    send_key('h01); send_key('h02); send_key('h14); send_key('h03); send_key('h04);
    check("mul pre result", b0.result, 'h12);
    check("mul pre inreg",  b0.inreg,  'h34);
    @(negedge clk);
    drive(1'b1, 'h12);
    @(posedge clk); #1;
    check("mul busy", b0.busy, 1);
    check("mul ready", b0.ready, 0);
    check("mul inreg cleared", b0.inreg, 0);
    drive(1'b1, 'h13);
    cnt = 1;
    while (cnt < 40) begin
      @(posedge clk); #1;
      if (!b0.busy) break;
      cnt++;
    end
    drive(1'b0, 0);
    check("mul busy cycles", cnt, W);
    check("mul result0", b0.result, 'h03A8);
    check("mul ovf0",    b0.ovf,    0);
    check("mul result1", b1.result, 'h03A8);
    @(posedge clk); #1;
    check("mul cl not taken", b0.result, 'h03A8);
    send_key('h13);

    // Product overflow: wrap keeps low bits, saturate clamps.
    send_key('h0F); send_key('h0F); send_key('h0F); send_key('h0F);
    send_key('h14); send_key('h02); send_key('h12);
    check("mulovf result0", b0.result, 'hFFFE);
    check("mulovf ovf0",    b0.ovf,    1);
    check("mulovf result1", b1.result, 'hFFFF);
    check("mulovf ovf1",    b1.ovf,    1);
    send_key('h13);

    // Reset while the multiplier is running.
    send_key('h03); send_key('h14); send_key('h05);
    @(negedge clk);
    drive(1'b1, 'h12);
    @(posedge clk); #1;
    drive(1'b0, 0);
    check("abort busy before", b0.busy, 1);
    #2 nrst = 1'b0;
    #1;
`else
    // Reset with live state held in the registers.
    send_key('h09); send_key('h10); send_key('h04);
    #2 nrst = 1'b0;
    #1;
`endif
    check("abort result", b0.result, 0);
    check("abort inreg",  b0.inreg,  0);
    check("abort ovf",    b0.ovf,    0);
    check("abort busy",   b0.busy,   0);
    check("abort ready",  b0.ready,  1);
    @(negedge clk);
    nrst = 1'b1;

    // Random keys against the reference model.
    m0 = '{inreg: 0, result: 0, ovf: 1'b0, pend: 0};
    m1 = m0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 5) k = int'($urandom_range(0, 15));
      else k = int'($urandom_range(16, 31));
      send_key(k);
      m0 = model_key(m0, 1'b0, k);
      m1 = model_key(m1, 1'b1, k);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
